stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  - BCD MM:SS time base for the stopwatch. Sits between the debouncers/clock divider and the seven-segment controller.
//  - Counts up at 1 Hz.
//  - Adjust mode steps the selected field at 2 Hz.
//  - Owns the pause toggle.
//  - Single master clock; divider outputs arrive as one-cycle tick enables.
// PARAMETERS
//  MIN_MAX   59  highest minute value before wrap (0..99)
//  SEC_MAX   59  highest second value before wrap (0..99)
// PORTS
//  clk           in   1  master clock; every register on rising edge
//  rst           in   1  asynchronous, active-low reset
//  one_hz_tick   in   1  one-clk pulse per second (count enable)
//  two_hz_tick   in   1  one-clk pulse per half second (adjust enable)
//  sel           in   1  debounced; 0 = adjust minutes, 1 = adjust seconds
//  adj           in   1  debounced level; 1 = adjust mode
//  pause         in   1  debounced pause button level
//  lap           in   1  debounced lap button level (only with STOPWATCH_LAP_EN)
//  min1_count    out  4  minutes tens, BCD
//  min0_count    out  4  minutes units, BCD
//  sec1_count    out  4  seconds tens, BCD
//  sec0_count    out  4  seconds units, BCD
//  pause_state   out  1  1 = paused
//  rollover      out  1  one-clk pulse when MIN_MAX:SEC_MAX wraps to 00:00
// BEHAVIOUR
//  - Reset (rst=0, async): all digits 0; pause_state=0 (running); rollover=0; edge-detect regs 0.
//    First count starts after rst deasserts.
//  - Pause: internal pause_d register; rising edge (pause & ~pause_d) toggles pause_state.
//    Toggle is visible the cycle after the edge. A held button gives exactly one toggle.
//  - Count (adj=0, pause_state=0, one_hz_tick=1): time += 1 s, 1-cycle latency.
//    - sec0 9->0 carries to sec1.
//    - sec==SEC_MAX -> sec=00 and carries to min.
//    - min==MIN_MAX with carry -> 00:00 plus rollover=1 for that cycle.
//  - Adjust (adj=1, two_hz_tick=1): selected field += 1, wraps at its MAX to 00.
//    - No carry into the other field; no rollover pulse.
//    - one_hz_tick is ignored while adj=1.
//    - Adjust works whether paused or not.
//  - adj=1 with no two_hz_tick: digits hold.
//  - sel change mid-adjust: takes effect on the next two_hz_tick.
//  - Same-cycle pause edge and one_hz_tick: the tick is gated by the pre-toggle pause_state (registered value).
//  - Paused: digits hold; adjust still applies.
//  - Digits never hold a non-BCD value or exceed MAX. The internal count is one integer per field, split to BCD combinationally.
//  - All outputs except the BCD split are registered.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//    - lap port exists.
//    - Rising edge of lap toggles an internal lap_hold flag.
//    - Entering hold snapshots the live count into display registers. Outputs show the snapshot while lap_hold=1.
//    - The live count keeps running underneath. Exiting hold returns the outputs to the live count the next cycle.
//    - Entering adjust mode clears lap_hold.
//    - Reset clears lap_hold and the snapshot.
//  STOPWATCH_LAP_EN undefined: no lap port; outputs always show the live count.
// TESTING
//  1. Pulse rst low mid-count at 12:34 -> all digits 0 immediately, pause_state=0, rollover=0.
//  2. 75 one_hz_ticks from 00:00 -> 01:15. Preload 59:59, one tick -> 00:00 plus a 1-cycle rollover pulse.
//  3. Pause press (held 100 clks) -> pause_state=1 one clk after the edge.
//     10 ticks -> digits hold. Second press -> resumes counting.
//  4. adj=1, sel=1 at 00:58, 3 two_hz_ticks -> 00:01, minutes unchanged, no rollover.
//     Interleaved one_hz_ticks -> ignored.
//  5. Pause edge on the same cycle as a one_hz_tick while running -> count advances by 1, then pause_state=1.
//  6. LAP_EN: at 00:10 press lap, 5 ticks -> outputs 00:10. Press lap again -> outputs 00:15 next clk.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Control and display bundle for stopwatch_counter.
// The lap member exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
    logic       one_hz_tick;
    logic       two_hz_tick;
    logic       sel;
    logic       adj;
    logic       pause;
`ifdef STOPWATCH_LAP_EN
    logic       lap;
`endif
    logic [3:0] min1_count;
    logic [3:0] min0_count;
    logic [3:0] sec1_count;
    logic [3:0] sec0_count;
    logic       pause_state;
    logic       rollover;

    modport master (
        output one_hz_tick, two_hz_tick, sel, adj, pause,
`ifdef STOPWATCH_LAP_EN
        output lap,
`endif
        input  min1_count, min0_count, sec1_count, sec0_count, pause_state, rollover
    );

    modport slave (
        input  one_hz_tick, two_hz_tick, sel, adj, pause,
`ifdef STOPWATCH_LAP_EN
        input  lap,
`endif
        output min1_count, min0_count, sec1_count, sec0_count, pause_state, rollover
    );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch time base: 1 Hz count, 2 Hz field adjust, pause toggle.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_counter_if.slave  sw
);

    localparam logic [6:0] MIN_TOP = 7'(MIN_MAX);
    localparam logic [6:0] SEC_TOP = 7'(SEC_MAX);

    logic [6:0] min_cnt;
    logic [6:0] sec_cnt;
    logic       pause_d;
    logic       pause_state;
    logic       rollover;
    logic       pause_rise;
    logic [6:0] disp_min;
    logic [6:0] disp_sec;

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] top);
        return (v >= top) ? '0 : v + 7'd1;
    endfunction

    assign pause_rise = sw.pause & ~pause_d;

    // Tick gating uses the registered pause_state, so a same-cycle press still lets the tick through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_cnt     <= '0;
            sec_cnt     <= '0;
            pause_d     <= 1'b0;
            pause_state <= 1'b0;
            rollover    <= 1'b0;
        end else begin
            pause_d  <= sw.pause;
            rollover <= 1'b0;
            if (pause_rise)
                pause_state <= ~pause_state;

            if (sw.adj) begin
                if (sw.two_hz_tick) begin
                    if (sw.sel)
                        sec_cnt <= wrap_inc(sec_cnt, SEC_TOP);
                    else
                        min_cnt <= wrap_inc(min_cnt, MIN_TOP);
                end
            end else if (sw.one_hz_tick && !pause_state) begin
                if (sec_cnt >= SEC_TOP) begin
                    sec_cnt <= '0;
                    min_cnt <= wrap_inc(min_cnt, MIN_TOP);
                    if (min_cnt >= MIN_TOP)
                        rollover <= 1'b1;
                end else begin
                    sec_cnt <= sec_cnt + 7'd1;
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_d;
    logic       adj_d;
    logic       lap_hold;
    logic [6:0] snap_min;
    logic [6:0] snap_sec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_d    <= 1'b0;
            adj_d    <= 1'b0;
            lap_hold <= 1'b0;
            snap_min <= '0;
            snap_sec <= '0;
        end else begin
            lap_d <= sw.lap;
            adj_d <= sw.adj;
            if (sw.adj && !adj_d) begin
                lap_hold <= 1'b0;
            end else if (sw.lap && !lap_d) begin
                lap_hold <= ~lap_hold;
                if (!lap_hold) begin
                    snap_min <= min_cnt;
                    snap_sec <= sec_cnt;
                end
            end
        end
    end

    assign disp_min = lap_hold ? snap_min : min_cnt;
    assign disp_sec = lap_hold ? snap_sec : sec_cnt;
`else
    assign disp_min = min_cnt;
    assign disp_sec = sec_cnt;
`endif

    assign sw.min1_count  = 4'(disp_min / 7'd10);
    assign sw.min0_count  = 4'(disp_min % 7'd10);
    assign sw.sec1_count  = 4'(disp_sec / 7'd10);
    assign sw.sec0_count  = 4'(disp_sec % 7'd10);
    assign sw.pause_state = pause_state;
    assign sw.rollover    = rollover;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: directed stimulus pushes expected
// display/status values, a negedge monitor pops and compares them.
module tb_stopwatch_counter;

    logic clk;
    logic rst;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .MIN_MAX (59),
        .SEC_MAX (59)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    typedef struct {
        string      name;
        logic [15:0] digits;
        logic       ps;
        logic       ro;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every queued expectation is compared against the outputs at the falling edge.
    exp_t mon_e;
    logic [15:0] mon_d;
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            mon_d = {sw_if.min1_count, sw_if.min0_count, sw_if.sec1_count, sw_if.sec0_count};
            checks++;
            if (mon_d !== mon_e.digits || sw_if.pause_state !== mon_e.ps || sw_if.rollover !== mon_e.ro) begin
                failures++;
                $display("FAIL %s: got %h ps=%b ro=%b, expected %h ps=%b ro=%b",
                         mon_e.name, mon_d, sw_if.pause_state, sw_if.rollover,
                         mon_e.digits, mon_e.ps, mon_e.ro);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_hz(input int n);
        repeat (n) begin
            sw_if.one_hz_tick = 1'b1;
            step();
            sw_if.one_hz_tick = 1'b0;
        end
    endtask

    task automatic two_hz(input int n);
        repeat (n) begin
            sw_if.two_hz_tick = 1'b1;
            step();
            sw_if.two_hz_tick = 1'b0;
        end
    endtask

    // Push the expected MM:SS/status and let the monitor sample it at the next falling edge.
    task automatic expect_out(input string name, input int mm, input int ss, input logic ps, input logic ro);
        exp_t e;
        e.name   = name;
        e.digits = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        e.ps     = ps;
        e.ro     = ro;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b0;
        sw_if.one_hz_tick = 1'b0;
        sw_if.two_hz_tick = 1'b0;
        sw_if.sel         = 1'b0;
        sw_if.adj         = 1'b0;
        sw_if.pause       = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw_if.lap         = 1'b0;
`endif
        repeat (3) step();
        expect_out("reset_state", 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        step();

        // Counting with carries
        one_hz(9);
        expect_out("count_9", 0, 9, 1'b0, 1'b0);
        one_hz(1);
        expect_out("sec0_carry", 0, 10, 1'b0, 1'b0);
        one_hz(50);
        expect_out("sec_to_min_carry", 1, 0, 1'b0, 1'b0);
        one_hz(15);
        expect_out("count_75", 1, 15, 1'b0, 1'b0);

        // Set 12:34 via adjust, pause it, then async reset mid-cycle
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b0;
        two_hz(11);
        expect_out("adj_min_12", 12, 15, 1'b0, 1'b0);
        sw_if.sel = 1'b1;
        two_hz(19);
        expect_out("adj_sec_34", 12, 34, 1'b0, 1'b0);
        sw_if.adj = 1'b0;
        sw_if.pause = 1'b1;
        step();
        expect_out("pause_before_reset", 12, 34, 1'b1, 1'b0);
        sw_if.pause = 1'b0;
        step();
        #2 rst = 1'b0;
        expect_out("async_reset", 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        step();

        // Adjust seconds with no carry; one_hz ignored
        one_hz(58);
        expect_out("count_58", 0, 58, 1'b0, 1'b0);
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b1;
        sw_if.one_hz_tick = 1'b1;
        two_hz(1);
        sw_if.one_hz_tick = 1'b0;
        expect_out("adj_sec_59", 0, 59, 1'b0, 1'b0);
        one_hz(1);
        expect_out("adj_ignore_1hz", 0, 59, 1'b0, 1'b0);
        two_hz(1);
        expect_out("adj_sec_wrap_no_carry", 0, 0, 1'b0, 1'b0);
        sw_if.one_hz_tick = 1'b1;
        two_hz(1);
        sw_if.one_hz_tick = 1'b0;
        expect_out("adj_sec_01", 0, 1, 1'b0, 1'b0);
        repeat (3) step();
        expect_out("adj_hold_no_tick", 0, 1, 1'b0, 1'b0);
        sw_if.sel = 1'b0;
        two_hz(1);
        expect_out("sel_switch_min", 1, 1, 1'b0, 1'b0);

        // Preload 59:59 and roll over
        two_hz(58);
        sw_if.sel = 1'b1;
        two_hz(58);
        expect_out("preload_5959", 59, 59, 1'b0, 1'b0);
        sw_if.adj = 1'b0;
        one_hz(1);
        expect_out("rollover_pulse", 0, 0, 1'b0, 1'b1);
        step();
        expect_out("rollover_one_cycle", 0, 0, 1'b0, 1'b0);

        // Pause held for 100 clocks, ticks ignored, adjust still applies
        sw_if.pause = 1'b1;
        step();
        expect_out("pause_toggle_on", 0, 0, 1'b1, 1'b0);
        repeat (99) step();
        expect_out("pause_held_single_toggle", 0, 0, 1'b1, 1'b0);
        sw_if.pause = 1'b0;
        one_hz(10);
        expect_out("paused_hold", 0, 0, 1'b1, 1'b0);
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b1;
        two_hz(1);
        expect_out("adjust_while_paused", 0, 1, 1'b1, 1'b0);
        sw_if.adj = 1'b0;
        sw_if.pause = 1'b1;
        step();
        expect_out("pause_toggle_off", 0, 1, 1'b0, 1'b0);
        sw_if.pause = 1'b0;
        step();
        one_hz(3);
        expect_out("resume_count", 0, 4, 1'b0, 1'b0);

        // Pause edge coincident with a tick: tick still counts
        sw_if.pause = 1'b1;
        one_hz(1);
        expect_out("pause_same_cycle_tick", 0, 5, 1'b1, 1'b0);
        sw_if.pause = 1'b0;
        one_hz(1);
        expect_out("paused_after_same_cycle", 0, 5, 1'b1, 1'b0);

`ifdef STOPWATCH_LAP_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        one_hz(10);
        expect_out("lap_start", 0, 10, 1'b0, 1'b0);
        sw_if.lap = 1'b1;
        step();
        sw_if.lap = 1'b0;
        one_hz(5);
        expect_out("lap_hold_snapshot", 0, 10, 1'b0, 1'b0);
        sw_if.lap = 1'b1;
        step();
        sw_if.lap = 1'b0;
        expect_out("lap_release_live", 0, 15, 1'b0, 1'b0);
        sw_if.lap = 1'b1;
        step();
        sw_if.lap = 1'b0;
        one_hz(2);
        expect_out("lap_hold_again", 0, 15, 1'b0, 1'b0);
        sw_if.adj = 1'b1;
        step();
        expect_out("adj_clears_lap", 0, 17, 1'b0, 1'b0);
        sw_if.adj = 1'b0;
        step();
`endif

        step();
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
